// File: rtl/instr_queue.sv
// ---------------------------------------------------------------------------
// instr_queue : circular {pc, instr} FIFO between fetch and decode/dispatch.
// Optional zero-latency bypass when built with INSTR_QUEUE_BYPASS_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instr_queue #(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq,
  input  logic [31:0]      enq_pc,
  input  logic [31:0]      enq_instr,
  input  logic             deq,
  output logic             FIFO_full,
  output logic             empty,
  output logic             deq_valid,
  output logic [31:0]      deq_pc,
  output logic [31:0]      deq_instr,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [63:0]    mem_q [DEPTH];
  logic [PTR_W:0] head_q, head_d;
  logic [PTR_W:0] tail_q, tail_d;

  logic           bypass;
  logic           do_enq;
  logic           do_deq;
  logic [63:0]    head_entry;

  assign empty     = (head_q == tail_q);
  assign FIFO_full = (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]) &&
                     (head_q[PTR_W] != tail_q[PTR_W]);
  assign count     = tail_q - head_q;

`ifdef INSTR_QUEUE_BYPASS_EN
  assign bypass = empty && enq && !flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry consumed the same cycle is never written.
  assign do_enq = enq && !FIFO_full && !flush && !(bypass && deq);
  assign do_deq = deq && !empty && !flush;

  assign head_entry = mem_q[head_q[PTR_W-1:0]];
  assign deq_valid  = !empty || bypass;

  always_comb begin
    deq_pc    = 32'd0;
    deq_instr = 32'd0;
    if (bypass) begin
      deq_pc    = enq_pc;
      deq_instr = enq_instr;
    end else if (!empty) begin
      deq_pc    = head_entry[63:32];
      deq_instr = head_entry[31:0];
    end
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (do_enq) tail_d = tail_q + 1'b1;
      if (do_deq) head_d = head_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Storage carries no reset; only pointer state defines validity.
  always_ff @(posedge clk) begin
    if (do_enq) mem_q[tail_q[PTR_W-1:0]] <= {enq_pc, enq_instr};
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count <= DEPTH_CNT);
`ifdef INSTR_QUEUE_PROTOCOL_CHECK
      assert (!(enq && FIFO_full));
`endif
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_queue : directed self-checking bench for instr_queue at DEPTH=4.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_instr_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             enq = 1'b0;
  logic [31:0]      enq_pc = 32'd0;
  logic [31:0]      enq_instr = 32'd0;
  logic             deq = 1'b0;
  logic             FIFO_full;
  logic             empty;
  logic             deq_valid;
  logic [31:0]      deq_pc;
  logic [31:0]      deq_instr;
  logic [PTR_W:0]   count;

  int n_cmp = 0;
  int n_err = 0;

  instr_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .enq       (enq),
    .enq_pc    (enq_pc),
    .enq_instr (enq_instr),
    .deq       (deq),
    .FIFO_full (FIFO_full),
    .empty     (empty),
    .deq_valid (deq_valid),
    .deq_pc    (deq_pc),
    .deq_instr (deq_instr),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    enq       = 1'b1;
    enq_pc    = pc;
    enq_instr = ~pc;
    tick();
    enq       = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_cmp++; if (FIFO_full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", FIFO_full); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_cmp++; if (deq_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", deq_valid); end
    n_cmp++; if (deq_pc !== 32'd0) begin n_err++; $display("FAIL reset_pc got=%h exp=0", deq_pc); end
    rst = 1'b0;
    tick();
    push(32'hAAAA_0000);
    push(32'hAAAA_0004);
    push(32'hAAAA_0008);
    n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL pre_reset_count got=%0d exp=3", count); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL async_reset_empty got=%b exp=1", empty); end
    n_cmp++; if (FIFO_full !== 1'b0) begin n_err++; $display("FAIL async_reset_full got=%b exp=0", FIFO_full); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL async_reset_count got=%0d exp=0", count); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) push(32'hAAAA_A000 + 32'(4*i));
    n_cmp++; if (FIFO_full !== 1'b1) begin n_err++; $display("FAIL fill_full got=%b exp=1", FIFO_full); end
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_count got=%0d exp=4", count); end
    push(32'hAAAA_A010);
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL overflow_count got=%0d exp=4", count); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (deq_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid[%0d] got=%b exp=1", i, deq_valid); end
      n_cmp++; if (deq_pc !== 32'hAAAA_A000 + 32'(4*i)) begin n_err++; $display("FAIL drain_pc[%0d] got=%h exp=%h", i, deq_pc, 32'hAAAA_A000 + 32'(4*i)); end
      n_cmp++; if (deq_instr !== ~(32'hAAAA_A000 + 32'(4*i))) begin n_err++; $display("FAIL drain_instr[%0d] got=%h exp=%h", i, deq_instr, ~(32'hAAAA_A000 + 32'(4*i))); end
      deq = 1'b1;
      tick();
      deq = 1'b0;
    end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL drained_empty got=%b exp=1", empty); end
    n_cmp++; if (deq_pc !== 32'd0) begin n_err++; $display("FAIL drained_pc got=%h exp=0", deq_pc); end
    deq = 1'b1;
    tick();
    deq = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL underflow_count got=%0d exp=0", count); end
  endtask

  task automatic test_wrap();
    logic [31:0] pc;
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 3; k++) push(32'hAAAA_A200 + 32'(4*(3*r+k)));
      n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL wrap_count[%0d] got=%0d exp=3", r, count); end
      for (int k = 0; k < 3; k++) begin
        pc = 32'hAAAA_A200 + 32'(4*(3*r+k));
        n_cmp++; if (deq_pc !== pc) begin n_err++; $display("FAIL wrap_pc[%0d.%0d] got=%h exp=%h", r, k, deq_pc, pc); end
        deq = 1'b1;
        tick();
        deq = 1'b0;
      end
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL wrap_empty[%0d] got=%b exp=1", r, empty); end
    end
  endtask

  task automatic test_simultaneous();
    push(32'hAAAA_A300);
    push(32'hAAAA_A304);
    enq = 1'b1; enq_pc = 32'hAAAA_A308; enq_instr = ~enq_pc; deq = 1'b1;
    #1;
    n_cmp++; if (deq_pc !== 32'hAAAA_A300) begin n_err++; $display("FAIL sim2_head got=%h exp=aaaaa300", deq_pc); end
    tick();
    enq = 1'b0; deq = 1'b0;
    n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL sim2_count got=%0d exp=2", count); end
    n_cmp++; if (deq_pc !== 32'hAAAA_A304) begin n_err++; $display("FAIL sim2_next got=%h exp=aaaaa304", deq_pc); end
    push(32'hAAAA_A30C);
    push(32'hAAAA_A310);
    n_cmp++; if (FIFO_full !== 1'b1) begin n_err++; $display("FAIL sim4_full got=%b exp=1", FIFO_full); end
    enq = 1'b1; enq_pc = 32'hAAAA_A314; enq_instr = ~enq_pc; deq = 1'b1;
    tick();
    enq = 1'b0; deq = 1'b0;
    n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL sim4_count got=%0d exp=3", count); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (deq_pc !== 32'hAAAA_A308 + 32'(4*i)) begin n_err++; $display("FAIL sim4_pc[%0d] got=%h exp=%h", i, deq_pc, 32'hAAAA_A308 + 32'(4*i)); end
      deq = 1'b1;
      tick();
      deq = 1'b0;
    end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL sim4_empty got=%b exp=1", empty); end
  endtask

  task automatic test_flush();
    push(32'hAAAA_A020);
    push(32'hAAAA_A024);
    push(32'hAAAA_A028);
    flush = 1'b1; enq = 1'b1; enq_pc = 32'hAAAA_A02C; deq = 1'b1;
    tick();
    flush = 1'b0; enq = 1'b0; deq = 1'b0;
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL flush_empty got=%b exp=1", empty); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_count got=%0d exp=0", count); end
    n_cmp++; if (deq_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got=%b exp=0", deq_valid); end
    push(32'hAAAA_A040);
    n_cmp++; if (deq_pc !== 32'hAAAA_A040) begin n_err++; $display("FAIL flush_after_pc got=%h exp=aaaaa040", deq_pc); end
    n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL flush_after_count got=%0d exp=1", count); end
    deq = 1'b1;
    tick();
    deq = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if (count !== 3'd0 || empty !== 1'b1) begin n_err++; $display("FAIL flush_idle got count=%0d empty=%b exp count=0 empty=1", count, empty); end
  endtask

  task automatic test_bypass();
    enq = 1'b1; enq_pc = 32'hAAAA_A100; enq_instr = ~enq_pc; deq = 1'b1;
    #1;
`ifdef INSTR_QUEUE_BYPASS_EN
    n_cmp++; if (deq_valid !== 1'b1) begin n_err++; $display("FAIL bypass_valid got=%b exp=1", deq_valid); end
    n_cmp++; if (deq_pc !== 32'hAAAA_A100) begin n_err++; $display("FAIL bypass_pc got=%h exp=aaaaa100", deq_pc); end
    tick();
    enq = 1'b0; deq = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL bypass_count got=%0d exp=0", count); end
`else
    n_cmp++; if (deq_valid !== 1'b0) begin n_err++; $display("FAIL nobypass_valid got=%b exp=0", deq_valid); end
    tick();
    enq = 1'b0; deq = 1'b0;
    n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL nobypass_count got=%0d exp=1", count); end
    n_cmp++; if (deq_pc !== 32'hAAAA_A100) begin n_err++; $display("FAIL nobypass_pc got=%h exp=aaaaa100", deq_pc); end
    deq = 1'b1;
    tick();
    deq = 1'b0;
`endif
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL bypass_end_empty got=%b exp=1", empty); end
  endtask

  initial begin
    #2;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_bypass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
